// File: rtl/piso_transmitter_pkg.sv
// Shared definitions for the serial shift-register link (transmitter side).
//   tx_state_t          : transmitter frame state (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH       : default word width, shared with the serial-in receiver
//   DEFAULT_IDLE_LEVEL  : default serial line level between frames
package piso_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    localparam int   DEFAULT_WIDTH      = 5;
    localparam logic DEFAULT_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/piso_transmitter.sv
// Parallel-in serial-out transmitter. Accepts a WIDTH-bit word on a single-cycle
// load handshake and sends it MSB first, one bit per clock, then pulses done.
// Frame period is WIDTH+2 cycles (WIDTH data bits, one done cycle, one idle cycle).
//
// Ports
//   clk        : clock, rising edge active
//   reset      : asynchronous active-high reset, aborts any frame in flight
//   data_in    : word to transmit, sampled only on an accepted load
//   load       : transmit request, honoured only while in_ready is high
//   in_ready   : high while idle and able to accept a load
//   serial_out : current serial bit, IDLE_LEVEL when no bit is being sent
//   bit_valid  : serial_out carries a data bit this cycle
//   done       : single-cycle end-of-frame pulse
module piso_transmitter
    import piso_transmitter_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter logic IDLE_LEVEL = DEFAULT_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             in_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             done
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    tx_state_t        r_state;
    tx_state_t        w_next_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_count;
    logic             w_accept;

    assign w_accept = (r_state == IDLE) && load;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs depend only on registered state and shreg, never on load/data_in.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        bit_valid    = 1'b0;
        done         = 1'b0;
        serial_out   = IDLE_LEVEL;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (load) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                bit_valid  = 1'b1;
                serial_out = r_shreg[WIDTH-1];
                if (r_count == LAST) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Load mux, shift register and bit counter share one register process.
    // The counter holds at LAST so it never wraps when WIDTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_shreg <= data_in;
            r_count <= '0;
        end else if (r_state == SHIFT) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            if (r_count != LAST) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_transmitter.sv
module tb_piso_transmitter;

    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NI-1:0] ld;
    logic [15:0]   data [NI];
    logic [NI-1:0] rdy, bv, dn, so;

    always #5 clk = ~clk;

    piso_transmitter #(.WIDTH(5), .IDLE_LEVEL(1'b0)) u_w5 (
        .clk(clk), .reset(reset), .data_in(data[0][4:0]), .load(ld[0]),
        .in_ready(rdy[0]), .serial_out(so[0]), .bit_valid(bv[0]), .done(dn[0]));

    piso_transmitter #(.WIDTH(2), .IDLE_LEVEL(1'b0)) u_w2 (
        .clk(clk), .reset(reset), .data_in(data[1][1:0]), .load(ld[1]),
        .in_ready(rdy[1]), .serial_out(so[1]), .bit_valid(bv[1]), .done(dn[1]));

    piso_transmitter #(.WIDTH(16), .IDLE_LEVEL(1'b0)) u_w16 (
        .clk(clk), .reset(reset), .data_in(data[2]), .load(ld[2]),
        .in_ready(rdy[2]), .serial_out(so[2]), .bit_valid(bv[2]), .done(dn[2]));

    // Reference model: a frame is a timeline measured in cycles since acceptance.
    // Cycles 0..W-1 carry bit W-1-t, cycle W is the done pulse, then idle again.
    int          widths [NI] = '{5, 2, 16};
    int          m_t    [NI];
    logic [15:0] m_word [NI];
    logic [15:0] rx     [NI];
    int          nstrb  [NI];
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        logic       load;
        logic [4:0] d;
        logic [3:0] exp;   // {in_ready, bit_valid, done, serial_out}
    } vec_t;
    vec_t tbl [7];

    function automatic logic [15:0] mask(int i);
        return 16'((32'd1 << widths[i]) - 1);
    endfunction

    function automatic logic [3:0] exp_out(int i);
        if (m_t[i] < 0)
            return 4'b1000;
        if (m_t[i] < widths[i])
            return {3'b010, m_word[i][widths[i] - 1 - m_t[i]]};
        return 4'b0010;
    endfunction

    task automatic chk(string name, int i, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%h expected=%h t=%0t", name, i, act, exp, $time);
        end
    endtask

    task automatic check_all(string name);
        for (int i = 0; i < NI; i++)
            chk(name, i, {12'd0, rdy[i], bv[i], dn[i], so[i]}, {12'd0, exp_out(i)});
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_t[i]   = -1;
            rx[i]    = '0;
            nstrb[i] = 0;
        end
    endtask

    // One clock: advance model with current inputs, capture the bit stream as a
    // bit_valid-enabled receiver would, then compare all outputs after the edge.
    task automatic step(string name);
        for (int i = 0; i < NI; i++) begin
            if (bv[i]) begin
                rx[i] = {rx[i][14:0], so[i]};
                nstrb[i]++;
            end
            if (m_t[i] < 0) begin
                if (ld[i]) begin
                    m_t[i]    = 0;
                    m_word[i] = data[i] & mask(i);
                end
            end else if (m_t[i] >= widths[i]) begin
                m_t[i] = -1;
            end else begin
                m_t[i]++;
            end
        end
        @(posedge clk);
        #1;
        check_all(name);
        for (int i = 0; i < NI; i++) begin
            if (dn[i]) begin
                chk("loopback", i, rx[i] & mask(i), m_word[i]);
                chk("strobes", i, 16'(nstrb[i]), 16'(widths[i]));
                nstrb[i] = 0;
            end
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'b10110, 4'b0101};
        tbl[1] = '{1'b0, 5'b00000, 4'b0100};
        tbl[2] = '{1'b0, 5'b00000, 4'b0101};
        tbl[3] = '{1'b0, 5'b00000, 4'b0101};
        tbl[4] = '{1'b0, 5'b00000, 4'b0100};
        tbl[5] = '{1'b0, 5'b00000, 4'b0010};
        tbl[6] = '{1'b0, 5'b00000, 4'b1000};

        reset = 1'b1;
        ld    = '0;
        for (int i = 0; i < NI; i++) data[i] = '0;
        model_reset();
        #12;
        check_all("reset_state");
        reset = 1'b0;

        for (int k = 0; k < 3; k++) step("idle");

        // Directed frame 10110 on the 5-bit instance
        for (int k = 0; k < 7; k++) begin
            ld[0]   = tbl[k].load;
            data[0] = {11'd0, tbl[k].d};
            step("table_model");
            chk("table", 0, {12'd0, rdy[0], bv[0], dn[0], so[0]}, {12'd0, tbl[k].exp});
        end

        // load held high: only E0 and E7 start frames; second frame is 00001
        ld[0]   = 1'b1;
        data[0] = 16'h001f;
        step("hold_load");
        data[0] = 16'h0001;
        for (int k = 0; k < 13; k++) step("hold_load");
        ld[0] = 1'b0;
        for (int k = 0; k < 2; k++) step("hold_load");

        // All 32 words on the 5-bit instance; other widths see random traffic
        for (int w = 0; w < 32; w++) begin
            for (int c = 0; c < 7; c++) begin
                ld[0]   = (c == 0);
                data[0] = (c == 0) ? 16'(w) : 16'($urandom);
                ld[1]   = 1'($urandom_range(0, 1));
                ld[2]   = 1'($urandom_range(0, 1));
                data[1] = 16'($urandom);
                data[2] = 16'($urandom);
                step("sweep32");
            end
        end
        ld = '0;
        for (int k = 0; k < 18; k++) step("drain");

        // Wide and narrow frames, load held high to exercise back-to-back period
        data[1] = 16'h0002;
        data[2] = 16'ha5c3;
        ld[1]   = 1'b1;
        ld[2]   = 1'b1;
        for (int k = 0; k < 20; k++) step("param_sweep");
        ld = '0;
        for (int k = 0; k < 18; k++) step("param_sweep");

        // Reset after the third bit of 01011 aborts the frame immediately
        ld[0]   = 1'b1;
        data[0] = 16'h000b;
        step("abort");
        ld[0] = 1'b0;
        step("abort");
        step("abort");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        #1;
        reset = 1'b0;
        ld[0]   = 1'b1;
        data[0] = 16'h0010;
        step("after_reset");
        ld[0] = 1'b0;
        for (int k = 0; k < 7; k++) step("after_reset");

        // Randomized traffic on all instances
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NI; i++) begin
                ld[i]   = ($urandom_range(0, 3) != 0);
                data[i] = 16'($urandom);
            end
            step("random");
        end
        ld = '0;
        for (int k = 0; k < 18; k++) step("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
